// File: rtl/shared_not_arbiter.sv
// Round-robin sequencer sharing one mynotgate inverter among NUM_REQ requesters.
// Define SHARED_NOT_STATS_EN to add the saturating txn_count output.

module mynotgate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = ~a;
endmodule

module shared_not_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
`ifdef SHARED_NOT_STATS_EN
  ,
  output logic [15:0]               txn_count
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [DATA_W-1:0]   win_op;
  logic [ID_W-1:0]     cand_id;
  int unsigned         cand;
  logic [DATA_W-1:0]   inv_y;

  mynotgate #(.WIDTH(DATA_W)) u_not (
    .a (op_q),
    .y (inv_y)
  );

  // Search upward from the pointer, wrapping at NUM_REQ-1; first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_W'(cand);
      if (!win_found && req[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
    win_op = DATA_W'(req_data >> (win_id * DATA_W));
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    gnt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          op_d    = win_op;
          id_d    = win_id;
          gnt_d   = NUM_REQ'(1) << win_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        state_d = EXEC;
      end
      EXEC: begin
        rsp_data_d  = inv_y;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

`ifdef SHARED_NOT_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    if (rsp_valid_q && rsp_ready && (txn_count_q != 16'hFFFF))
      txn_count_d = txn_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txn_count_q <= '0;
    else        txn_count_q <= txn_count_d;
  end

  assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_shared_not_arbiter.sv
// Self-checking bench for shared_not_arbiter: vector table plus scoreboard queues
// for grants and responses, with hand-written latency/backpressure/reset sequences.

module tb_shared_not_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;
`ifdef SHARED_NOT_STATS_EN
  logic [15:0]               txn_count;
`endif

  always #5 clk = ~clk;

  shared_not_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef SHARED_NOT_STATS_EN
    ,
    .txn_count (txn_count)
`endif
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int unsigned n;
    logic [7:0]  order;  // expected winner ids, first winner in [1:0]
  } vec_t;

  vec_t vecs[8];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [NUM_REQ-1:0]     exp_gnt_q[$];
  logic [ID_W+DATA_W-1:0] exp_rsp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(input logic [1:0] id, input logic [31:0] d);
    logic [7:0] b;
    b = d[id*8 +: 8];
    exp_gnt_q.push_back(4'b0001 << id);
    exp_rsp_q.push_back({id, ~b});
  endtask

  // Handshake seen before the edge is scored, then grants seen after the edge;
  // requesters drop req as soon as they observe their grant.
  task automatic step();
    logic [ID_W+DATA_W-1:0] e;
    logic [NUM_REQ-1:0]     g;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      check("rsp_expected", 32'(exp_rsp_q.size() != 0), 32'd1);
      if (exp_rsp_q.size() != 0) begin
        e = exp_rsp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e[DATA_W +: ID_W]));
        check("rsp_data", 32'(rsp_data), 32'(e[DATA_W-1:0]));
      end
    end
    @(negedge clk);
    if (gnt !== '0) begin
      check("gnt_expected", 32'(exp_gnt_q.size() != 0), 32'd1);
      if (exp_gnt_q.size() != 0) begin
        g = exp_gnt_q.pop_front();
        check("gnt", 32'(gnt), 32'(g));
      end
    end
    req = req & ~gnt;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 80; c++) begin
      if (exp_rsp_q.size() == 0 && exp_gnt_q.size() == 0) break;
      step();
    end
    check(name, 32'(exp_rsp_q.size() + exp_gnt_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1111, 32'h4433_2211, 4, 8'hE4};
    vecs[1] = '{4'b1111, 32'hF0E1_D2C3, 4, 8'hE4};
    vecs[2] = '{4'b0010, 32'h0000_A500, 1, 8'h01};
    vecs[3] = '{4'b0101, 32'h007E_0081, 2, 8'h02};
    vecs[4] = '{4'b1001, 32'h8000_0001, 2, 8'h03};
    vecs[5] = '{4'b1000, 32'h5500_0000, 1, 8'h03};
    vecs[6] = '{4'b0110, 32'h00CC_3300, 2, 8'h09};
    vecs[7] = '{4'b0001, 32'h0000_00FE, 1, 8'h00};

    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      req_data = vecs[v].data;
      for (int unsigned k = 0; k < vecs[v].n; k++)
        push_txn(vecs[v].order[2*k +: 2], vecs[v].data);
      req = vecs[v].req;
      wait_drain($sformatf("vec%0d_drain", v));
    end

    // Single request latency: gnt next cycle, rsp_valid two edges after sampling.
    req_data = 32'h0000_A500;
    req      = 4'b0010;
    push_txn(2'd1, req_data);
    step();
    check("lat_gnt", 32'(gnt), 32'h2);
    check("lat_busy", 32'(busy), 32'd1);
    step();
    check("lat_gnt_pulse", 32'(gnt), 32'd0);
    check("lat_valid_early", 32'(rsp_valid), 32'd0);
    step();
    check("lat_valid", 32'(rsp_valid), 32'd1);
    check("lat_id", 32'(rsp_id), 32'd1);
    check("lat_data", 32'(rsp_data), 32'h5A);
    step();
    check("lat_valid_once", 32'(rsp_valid), 32'd0);
    check("lat_idle", 32'(busy), 32'd0);

    // Backpressure with a second requester waiting.
    rsp_ready = 1'b0;
    req_data  = 32'h963C_0000;
    req       = 4'b1100;
    push_txn(2'd2, req_data);
    push_txn(2'd3, req_data);
    repeat (3) step();
    check("bp_valid_rise", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_id_hold", 32'(rsp_id), 32'd2);
      check("bp_data_hold", 32'(rsp_data), 32'hC3);
      check("bp_no_gnt", 32'(gnt), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_drain("bp_drain");

    // Operand changes after the latch edge must not reach the result.
    req_data = 32'h0000_000F;
    req      = 4'b0001;
    push_txn(2'd0, req_data);
    step();
    req_data[7:0] = 8'hFF;
    wait_drain("late_drain");

    // Reset while a response is pending.
    rsp_ready = 1'b0;
    req_data  = 32'h0077_0000;
    req       = 4'b0100;
    push_txn(2'd2, req_data);
    repeat (3) step();
    check("mid_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_rsp_q.delete();
    exp_gnt_q.delete();
    req       = '0;
    rsp_ready = 1'b1;
    check("mrst_gnt", 32'(gnt), 32'd0);
    check("mrst_valid", 32'(rsp_valid), 32'd0);
    check("mrst_data", 32'(rsp_data), 32'd0);
    check("mrst_id", 32'(rsp_id), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    // Pointer must be back at 0: requester 0 wins over 3.
    req_data = 32'h1200_0034;
    req      = 4'b1001;
    push_txn(2'd0, req_data);
    push_txn(2'd3, req_data);
    wait_drain("ptr_rst_drain");
`ifdef SHARED_NOT_STATS_EN
    check("stats_two", 32'(txn_count), 32'd2);
`endif
    req_data = 32'h0000_6600;
    req      = 4'b0010;
    push_txn(2'd1, req_data);
    wait_drain("final_drain");
`ifdef SHARED_NOT_STATS_EN
    check("stats_three", 32'(txn_count), 32'd3);
    force dut.txn_count_q = 16'hFFFE;
    step();
    release dut.txn_count_q;
    step();
    check("stats_forced", 32'(txn_count), 32'hFFFE);
    for (int t = 0; t < 2; t++) begin
      req_data = 32'h0000_0055;
      req      = 4'b0001;
      push_txn(2'd0, req_data);
      wait_drain("stats_drain");
    end
    check("stats_sat", 32'(txn_count), 32'hFFFF);
`endif

    check("sb_empty", 32'(exp_rsp_q.size() + exp_gnt_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
